// File: rtl/btn_arb_pkg.sv
// Shared types and helpers for the button event arbiter.
package btn_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam int MAX_BTN = 16;

    function automatic int deb_cnt_width(input int deb_cycles);
        return (deb_cycles > 2) ? $clog2(deb_cycles) : 1;
    endfunction

    // First set request strictly after ptr, wrapping modulo n; returns ptr if none set.
    function automatic logic [3:0] rr_next(input logic [MAX_BTN-1:0] req,
                                           input logic [3:0] ptr,
                                           input int n);
        logic [3:0] sel;
        logic       found;
        int         idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_BTN; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && !found && req[idx]) begin
                sel   = 4'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button lane: 2-flop synchroniser, stability counter, debounced level and rise pulse.
module btn_debounce
    import btn_arb_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);

    localparam int               CNT_W    = deb_cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic             deb_q_reg;
    logic             deb_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Counter only advances while the synchronised level disagrees with the accepted one.
    always_comb begin
        deb_next = deb_reg;
        cnt_next = '0;
        if (sync2_reg != deb_reg) begin
            if (cnt_reg == CNT_LAST) begin
                deb_next = ~deb_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            deb_q_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            deb_reg   <= deb_next;
            deb_q_reg <= deb_reg;
            cnt_reg   <= cnt_next;
        end
    end

    assign rise = deb_reg & ~deb_q_reg;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced push-button front end: one event per press, round-robin onto a valid/ready channel.
// Optional sticky per-button overrun output when BTN_OVERRUN_FLAG_EN is defined.
module button_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 16,
    parameter int ID_W       = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] pending
`ifdef BTN_OVERRUN_FLAG_EN
    ,
    output logic [N_BTN-1:0] overrun
`endif
);

    logic [N_BTN-1:0] rise;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_lane
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .btn_raw(btn_in[gi]),
                .rise   (rise[gi])
            );
        end
    endgenerate

    arb_state_t         state_reg;
    arb_state_t         state_next;
    logic [ID_W-1:0]    evt_id_reg;
    logic [ID_W-1:0]    evt_id_next;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [N_BTN-1:0]   pending_reg;
    logic [N_BTN-1:0]   pending_next;
    logic [N_BTN-1:0]   accept_mask;
    logic               accept;
    logic [MAX_BTN-1:0] req_ext;
    logic [3:0]         ptr_ext;
    logic [3:0]         pick;

    assign req_ext     = MAX_BTN'(pending_reg);
    assign ptr_ext     = 4'(rr_ptr_reg);
    assign pick        = rr_next(req_ext, ptr_ext, N_BTN);
    assign accept      = (state_reg == ST_OFFER) && evt_ready;
    assign accept_mask = accept ? (N_BTN'(1) << evt_id_reg) : '0;

    // A rise in the same cycle as its own acceptance keeps the flag set: the new press survives.
    always_comb begin
        state_next   = state_reg;
        evt_id_next  = evt_id_reg;
        rr_ptr_next  = rr_ptr_reg;
        pending_next = (pending_reg & ~accept_mask) | rise;
        case (state_reg)
            ST_IDLE: begin
                if (|pending_reg) begin
                    evt_id_next = ID_W'(pick);
                    state_next  = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    rr_ptr_next = evt_id_reg;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            evt_id_reg  <= '0;
            rr_ptr_reg  <= ID_W'(N_BTN - 1);
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            evt_id_reg  <= evt_id_next;
            rr_ptr_reg  <= rr_ptr_next;
            pending_reg <= pending_next;
        end
    end

    assign evt_valid = (state_reg == ST_OFFER);
    assign evt_id    = evt_id_reg;
    assign pending   = pending_reg;

`ifdef BTN_OVERRUN_FLAG_EN
    logic [N_BTN-1:0] overrun_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_reg <= '0;
        end else begin
            overrun_reg <= overrun_reg | (rise & pending_reg & ~accept_mask);
        end
    end

    assign overrun = overrun_reg;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench: directed table, hand sequences and randomized run against a behavioural model.
module tb_button_event_arbiter;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   btn_in = '0;
    logic           evt_ready = 1'b0;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic [N-1:0]   pending;
`ifdef BTN_OVERRUN_FLAG_EN
    logic [N-1:0]   overrun;
`endif

    int checks = 0;
    int errors = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN     (N),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .pending  (pending)
`ifdef BTN_OVERRUN_FLAG_EN
        ,
        .overrun  (overrun)
`endif
    );

    // Behavioural model: input delay line, sample-history debounce, pending set and rr arbiter.
    logic [N-1:0]   m_dly1, m_dly2;
    logic [DEB-1:0] m_hist [N];
    logic [N-1:0]   m_deb, m_deb_q, m_pend, m_ovr;
    bit             m_valid;
    int             m_id, m_rr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dly1 = '0; m_dly2 = '0;
        m_deb = '0; m_deb_q = '0; m_pend = '0; m_ovr = '0;
        for (int i = 0; i < N; i++) m_hist[i] = '0;
        m_valid = 0; m_id = 0; m_rr = N - 1;
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic r);
        logic [N-1:0] rs, acc;
        int pick;
        rs  = m_deb & ~m_deb_q;
        acc = '0;
        pick = 0;
        if (m_valid && r) acc[m_id] = 1'b1;
        m_ovr = m_ovr | (rs & m_pend & ~acc);
        if (m_valid) begin
            if (r) begin
                m_valid = 0;
                m_rr    = m_id;
            end
        end else if (m_pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_pend[(m_rr + k) % N]) begin
                    pick = (m_rr + k) % N;
                    break;
                end
            end
            m_id    = pick;
            m_valid = 1;
        end
        m_pend  = (m_pend & ~acc) | rs;
        m_deb_q = m_deb;
        for (int i = 0; i < N; i++) begin
            m_hist[i] = {m_hist[i][DEB-2:0], m_dly2[i]};
            if (m_deb[i] ? (m_hist[i] == '0) : (&m_hist[i])) m_deb[i] = ~m_deb[i];
        end
        m_dly2 = m_dly1;
        m_dly1 = b;
    endtask

    task automatic cycle(input logic [N-1:0] b, input logic r);
        btn_in    = b;
        evt_ready = r;
        if (evt_valid && r) begin
            acc_q.push_back(int'(evt_id));
            $display("evt id=%0d accepted at %0t", evt_id, $time);
        end
        model_step(b, r);
        @(posedge clk);
        #1;
        chk("model_valid", int'(evt_valid), int'(m_valid));
        chk("model_id", int'(evt_id), m_id);
        chk("model_pending", int'(pending), int'(m_pend));
`ifdef BTN_OVERRUN_FLAG_EN
        chk("model_overrun", int'(overrun), int'(m_ovr));
`endif
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        btn_in    = '0;
        evt_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_id", int'(evt_id), 0);
        chk("rst_pending", int'(pending), 0);
`ifdef BTN_OVERRUN_FLAG_EN
        chk("rst_overrun", int'(overrun), 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        acc_q.delete();
    endtask

    task automatic wait_valid(input logic [N-1:0] b, input string name);
        int n;
        n = 0;
        while (!evt_valid && n < 20) begin
            cycle(b, 1'b0);
            n++;
        end
        chk(name, int'(evt_valid), 1);
    endtask

    typedef struct {
        logic [N-1:0] btn;
        logic         rdy;
        logic         exp_valid;
        int           exp_id;
        logic [N-1:0] exp_pend;
    } vec_t;

    vec_t tbl[12];
    int   hold[N];
    logic [N-1:0] rb;

    initial begin
        for (int r = 0; r < 6; r++) tbl[r] = '{4'b0100, 1'b1, 1'b0, 0, 4'b0000};
        tbl[6] = '{4'b0100, 1'b1, 1'b0, 0, 4'b0100};
        tbl[7] = '{4'b0100, 1'b1, 1'b1, 2, 4'b0100};
        for (int r = 8; r < 12; r++) tbl[r] = '{4'b0100, 1'b1, 1'b0, 2, 4'b0000};

        #2;
        // Test 1: single clean press, exact latency
        do_reset();
        for (int r = 0; r < 12; r++) begin
            cycle(tbl[r].btn, tbl[r].rdy);
            chk($sformatf("t1_valid_r%0d", r), int'(evt_valid), int'(tbl[r].exp_valid));
            chk($sformatf("t1_id_r%0d", r), int'(evt_id), tbl[r].exp_id);
            chk($sformatf("t1_pend_r%0d", r), int'(pending), int'(tbl[r].exp_pend));
        end
        repeat (8) cycle(4'b0100, 1'b1);
        repeat (12) cycle(4'b0000, 1'b1);
        chk("t1_event_count", acc_q.size(), 1);

        // Test 2: glitch shorter than the debounce window
        do_reset();
        repeat (3) cycle(4'b0010, 1'b1);
        repeat (12) cycle(4'b0000, 1'b1);
        chk("t2_event_count", acc_q.size(), 0);
        chk("t2_pending", int'(pending), 0);

        // Test 3: simultaneous presses drain in round-robin order
        do_reset();
        repeat (20) cycle(4'b1011, 1'b1);
        chk("t3_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("t3_first", acc_q[0], 0);
            chk("t3_second", acc_q[1], 1);
            chk("t3_third", acc_q[2], 3);
        end
        repeat (10) cycle(4'b0000, 1'b1);

        // Test 4: stalled offer holds stable, then next pending id
        do_reset();
        wait_valid(4'b1001, "t4_offer_seen");
        for (int k = 0; k < 10; k++) begin
            cycle(4'b1001, 1'b0);
            chk("t4_hold_valid", int'(evt_valid), 1);
            chk("t4_hold_id", int'(evt_id), 0);
        end
        cycle(4'b1001, 1'b1);
        chk("t4_bubble", int'(evt_valid), 0);
        cycle(4'b1001, 1'b0);
        chk("t4_next_valid", int'(evt_valid), 1);
        chk("t4_next_id", int'(evt_id), 3);
        cycle(4'b1001, 1'b1);
        repeat (10) cycle(4'b0000, 1'b1);
        chk("t4_count", acc_q.size(), 2);

        // Test 5: second press while pending merges
        do_reset();
        repeat (12) cycle(4'b0100, 1'b0);
        repeat (10) cycle(4'b0000, 1'b0);
        repeat (10) cycle(4'b0100, 1'b0);
        chk("t5_pending_held", int'(pending), 4);
        repeat (8) cycle(4'b0100, 1'b1);
        chk("t5_count", acc_q.size(), 1);
        chk("t5_pending_clear", int'(pending), 0);
`ifdef BTN_OVERRUN_FLAG_EN
        chk("t5_overrun", int'(overrun[2]), 1);
`endif

        // Test 6: reset during an offer drops everything
        do_reset();
        wait_valid(4'b0001, "t6_offer_seen");
        do_reset();
        repeat (15) cycle(4'b0000, 1'b1);
        chk("t6_no_event", acc_q.size(), 0);

        // Randomized run against the model
        do_reset();
        rb = '0;
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    rb[i]   = ~rb[i];
                    hold[i] = $urandom_range(1, 12);
                end
            end
            cycle(rb, ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Front-end controller for the board's push-button inputs.
- Each of N_BTN raw button levels is synchronised, debounced and reduced to one event per press (rising edge).
- Pending events share a single event channel: round-robin arbitration, valid/ready handshake.
- Sits between the raw pins and the downstream command FSM, so that FSM only ever sees one button event at a time.

Parameters:
- N_BTN, 4, number of button inputs (2..16).
- DEB_CYCLES, 16, consecutive stable cycles required to accept a level change (>=2).
- ID_W, $clog2(N_BTN), width of the event id.

Ports:
- clk  in  1  system clock, all state rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- btn_in  in  N_BTN  raw, asynchronous button levels, active-high.
- evt_valid  out  1  an event is offered on evt_id.
- evt_id  out  ID_W  index of the button whose press is offered.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a rising edge.
- pending  out  N_BTN  per-button sticky "press not yet delivered" flags.

Behaviour:
- Reset (reset=0, async) clears everything:
  - sync flops, debounced levels and debounce counters = 0.
  - pending = 0, evt_valid = 0, evt_id = 0, round-robin pointer = N_BTN-1 (so button 0 wins first), FSM = IDLE.
- Synchroniser: 2-flop per input; sync[i] lags btn_in[i] by 2 cycles.
- Debounce, per input:
  - Counter counts consecutive cycles where sync[i] != deb[i]; it resets to 0 whenever they are equal.
  - When the count reaches DEB_CYCLES-1 with inequality still present, deb[i] toggles and the counter clears.
  - Result: deb[i] changes DEB_CYCLES cycles after sync[i] settles.
  - Glitches shorter than DEB_CYCLES never change deb[i].
- Edge detect: rise[i] = deb[i] & ~deb_q[i] (deb_q is deb delayed one cycle). Falling edges are ignored.
- Pending: pending[i] is set the cycle after rise[i].
  - It clears only on acceptance of an event with evt_id==i.
  - rise[i] while pending[i] is already 1: press is merged (no queueing beyond one per button).
  - rise[i] in the same cycle as acceptance of id i: set wins, pending[i] stays 1 and a fresh event is later offered.
- FSM, 2 states:
  - IDLE: evt_valid=0. If any pending bit is set, pick the first set index strictly after the rr pointer, wrapping modulo N_BTN. Register it into evt_id and go to OFFER.
  - OFFER: evt_valid=1 and evt_id held stable. On evt_ready:
    - clear pending[evt_id];
    - rr pointer <= evt_id;
    - go to IDLE.
  - OFFER has no timeout; evt_valid stays high indefinitely until accepted.
- Throughput: at most one event per 2 cycles (mandatory IDLE bubble).
- Latency: deb[i] rise at cycle T → pending[i] at T+1 → evt_valid at T+2 if FSM is IDLE at T+1.
- evt_ready while evt_valid=0 is ignored.
- Reset asserted mid-OFFER drops the offered event and all pending events; no event is emitted after release until new presses arrive.

Optional Feature:
- Macro: BTN_OVERRUN_FLAG_EN.
- When defined: adds output port overrun (N_BTN, sticky).
  - overrun[i] sets when rise[i] occurs while pending[i]=1 and no acceptance of id i happens in that cycle.
  - Cleared only by reset.
- When undefined: the port and its logic are absent; merged presses are silently dropped. All other behaviour is identical.

Decomposition:
- Package btn_arb_pkg:
  - FSM state encoding (ST_IDLE, ST_OFFER).
  - Function for the debounce counter width, $clog2(DEB_CYCLES).
  - Round-robin "next set bit after pointer" function.
- Sub-module btn_debounce: one input, 2-flop sync + counter + deb output + rise pulse. Instantiated N_BTN times via generate.
- The arbiter FSM stays in the top.

Test Plan (N_BTN=4, DEB_CYCLES=4):
1. Reset then btn_in[2] held high 20 cycles → exactly one event, evt_id=2, evt_valid first high 8 cycles after the input edge (2 sync + 4 deb + 2), pending=0000 after accept.
2. btn_in[1] pulse of 3 cycles (shorter than DEB_CYCLES) → no evt_valid, pending stays 0000.
3. Buttons 0,1,3 rise in the same cycle, evt_ready=1 always → events emitted in order 0,1,3, evt_valid high every other cycle.
4. Hold evt_ready=0 for 10 cycles with event 0 offered → evt_valid and evt_id=0 stable throughout; accept on cycle 11; next offer is id 3 if pending[3]=1.
5. Second clean press of btn 2 while pending[2]=1 → only one event for id 2; with BTN_OVERRUN_FLAG_EN, overrun[2]=1 afterwards.
6. Assert reset=0 while evt_valid=1 → evt_valid, pending and evt_id go to 0 immediately; after release, no event until a new debounced press.
